// File: rtl/dff_reset_en.sv
// Capture register with a synchronous active-high reset and a load enable.
// Typical use: latch a command packet on its handshake edge, then hold it
// stable while the transaction runs. data_o comes straight from the flops,
// so there is no combinational path from any input to the output.
module dff_reset_en #(
    parameter int unsigned                width_p     = 1,
    parameter logic [width_p-1:0]         reset_val_p = '0
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               en_i,
    input  logic [width_p-1:0] data_i,
    output logic [width_p-1:0] data_o
);

    // A zero-width register has no meaning; refuse to elaborate one.
    if (width_p < 1) begin : g_bad_width
        $error("dff_reset_en: width_p must be at least 1");
    end

    logic [width_p-1:0] data_q;
    logic [width_p-1:0] data_d;

    // Next-state select: reset beats enable, enable beats hold. Reset is
    // tested first so an unknown en_i cannot leak into the reset value.
    always_comb begin
        data_d = data_q;
        if (reset_i) begin
            data_d = reset_val_p;
        end else if (en_i) begin
            data_d = data_i;
        end
    end

    // State register; reset is synchronous, so it only acts on a rising edge.
    always_ff @(posedge clk_i) begin
        data_q <= data_d;
    end

    assign data_o = data_q;

endmodule

// File: tb/tb_dff_reset_en.sv
// Directed self-checking bench for dff_reset_en: an 8-bit instance with a zero
// reset value and a 64-bit instance with a non-zero reset value.
module tb_dff_reset_en;

    localparam logic [63:0] Rst64 = 64'hDEAD_BEEF_0000_0001;

    logic        clk;
    logic        rst8;
    logic        en8;
    logic [7:0]  din8;
    logic [7:0]  dout8;
    logic        rst64;
    logic        en64;
    logic [63:0] din64;
    logic [63:0] dout64;

    int checks;
    int errors;

    dff_reset_en #(
        .width_p    (8),
        .reset_val_p(8'h00)
    ) u_dut8 (
        .clk_i  (clk),
        .reset_i(rst8),
        .en_i   (en8),
        .data_i (din8),
        .data_o (dout8)
    );

    dff_reset_en #(
        .width_p    (64),
        .reset_val_p(Rst64)
    ) u_dut64 (
        .clk_i  (clk),
        .reset_i(rst64),
        .en_i   (en64),
        .data_i (din64),
        .data_o (dout64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst8 = 1'b1;
        en8  = 1'b1;
        din8 = 8'hA5;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (dout8 !== 8'h00) begin
                errors++;
                $display("FAIL reset edge %0d: data_o=%h expected=%h", i, dout8, 8'h00);
            end
        end
    endtask

    task automatic test_load_hold();
        rst8 = 1'b0;
        en8  = 1'b1;
        din8 = 8'h3C;
        tick();
        checks++;
        if (dout8 !== 8'h3C) begin
            errors++;
            $display("FAIL load: data_o=%h expected=%h", dout8, 8'h3C);
        end
        en8  = 1'b0;
        din8 = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (dout8 !== 8'h3C) begin
                errors++;
                $display("FAIL hold cycle %0d: data_o=%h expected=%h", i, dout8, 8'h3C);
            end
        end
    endtask

    task automatic test_streaming();
        logic [7:0] v;
        rst8 = 1'b0;
        en8  = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            v    = 8'(i);
            din8 = v;
            tick();
            checks++;
            if (dout8 !== v) begin
                errors++;
                $display("FAIL stream %0d: data_o=%h expected=%h", i, dout8, v);
            end
        end
    endtask

    task automatic test_collision();
        rst8 = 1'b0;
        en8  = 1'b1;
        din8 = 8'h55;
        tick();
        checks++;
        if (dout8 !== 8'h55) begin
            errors++;
            $display("FAIL collision preload: data_o=%h expected=%h", dout8, 8'h55);
        end
        rst8 = 1'b1;
        din8 = 8'hAA;
        tick();
        checks++;
        if (dout8 !== 8'h00) begin
            errors++;
            $display("FAIL collision reset wins: data_o=%h expected=%h", dout8, 8'h00);
        end
        rst8 = 1'b0;
        en8  = 1'b0;
        tick();
        checks++;
        if (dout8 !== 8'h00) begin
            errors++;
            $display("FAIL collision hold after reset: data_o=%h expected=%h", dout8, 8'h00);
        end
        // Reset with an unknown enable must still give the reset value.
        en8  = 1'b1;
        din8 = 8'h77;
        tick();
        rst8 = 1'b1;
        en8  = 1'bx;
        din8 = 8'h99;
        tick();
        checks++;
        if (dout8 !== 8'h00) begin
            errors++;
            $display("FAIL reset with en X: data_o=%h expected=%h", dout8, 8'h00);
        end
        rst8 = 1'b0;
        en8  = 1'b0;
    endtask

    task automatic test_wide();
        rst64 = 1'b1;
        en64  = 1'b1;
        din64 = 64'h0123_4567_89AB_CDEF;
        tick();
        checks++;
        if (dout64 !== Rst64) begin
            errors++;
            $display("FAIL wide reset: data_o=%h expected=%h", dout64, Rst64);
        end
        rst64 = 1'b0;
        din64 = '1;
        tick();
        checks++;
        if (dout64 !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            errors++;
            $display("FAIL wide load ones: data_o=%h expected=%h", dout64, 64'hFFFF_FFFF_FFFF_FFFF);
        end
        en64  = 1'b0;
        din64 = 64'h0;
        tick();
        checks++;
        if (dout64 !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            errors++;
            $display("FAIL wide hold: data_o=%h expected=%h", dout64, 64'hFFFF_FFFF_FFFF_FFFF);
        end
    endtask

    task automatic test_midcycle_reset();
        rst8 = 1'b0;
        en8  = 1'b1;
        din8 = 8'h5A;
        tick();
        en8 = 1'b0;
        // Pulse reset between edges: nothing may change.
        #2 rst8 = 1'b1;
        #1;
        checks++;
        if (dout8 !== 8'h5A) begin
            errors++;
            $display("FAIL midcycle during pulse: data_o=%h expected=%h", dout8, 8'h5A);
        end
        #1 rst8 = 1'b0;
        #1;
        checks++;
        if (dout8 !== 8'h5A) begin
            errors++;
            $display("FAIL midcycle after pulse: data_o=%h expected=%h", dout8, 8'h5A);
        end
        tick();
        checks++;
        if (dout8 !== 8'h5A) begin
            errors++;
            $display("FAIL midcycle next edge: data_o=%h expected=%h", dout8, 8'h5A);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst8   = 1'b1;
        en8    = 1'b0;
        din8   = 8'h00;
        rst64  = 1'b1;
        en64   = 1'b0;
        din64  = 64'h0;
        #1;
        test_reset();
        test_load_hold();
        test_streaming();
        test_collision();
        test_wide();
        test_midcycle_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
